aes_sca_sequencer: RTL
======================

// Module: aes_sca_sequencer
// PURPOSE
//  Command-side master for the AES core: turns a single start request into init/next
//  handshake sequences to the core and captures the block count and completion status.
//  Drives a scope trigger that frames each encryption for side-channel capture.
//  Sits between the capture-control logic (host/UART command decoder) and aes_top.
// PARAMETERS
//  CNT_W      16    width of block counter and num_blocks
//  GAP_CYC    4     idle cycles between consecutive blocks (trigger low; scope re-arm)
//  TIMEOUT    1024  watchdog limit, cycles spent in any one waiting state
// PORTS
//  clk               in   1      system clock, all logic on rising edge
//  reset_n           in   1      asynchronous, active-low reset
//  start             in   1      run request; sampled only in IDLE
//  rekey             in   1      sampled with start: 1 = issue key init before first block
//  num_blocks        in   CNT_W  encryptions to run; sampled with start
//  busy              out  1      high whenever state != IDLE
//  done              out  1      one-cycle pulse at end of run (normal or error)
//  error             out  1      watchdog fired; sticky until next accepted start
//  blocks_done       out  CNT_W  results received in current/last run
//  trigger           out  1      scope trigger, high from aes_next pulse to result accept
//  aes_init          out  1      one-cycle key-expansion request to core
//  aes_next          out  1      one-cycle encrypt request to core
//  aes_ready         in   1      core idle (level)
//  aes_result_valid  in   1      core result valid (level)
// BEHAVIOUR
//  Reset (any time, incl. mid-run): state IDLE; all outputs 0; counters 0. No pulse emitted.
//  All outputs registered. States: IDLE, INIT, INIT_BUSY, INIT_WAIT, NEXT, NEXT_BUSY,
//   NEXT_WAIT, GAP, DONE.
//  IDLE: start=1 -> latch rekey/num_blocks, clear error and blocks_done;
//   rekey=1 -> INIT; else num_blocks!=0 -> NEXT; else -> DONE. start in other states ignored.
//  INIT: wait aes_ready=1; then aes_init=1 for exactly one cycle -> INIT_BUSY.
//  INIT_BUSY: wait aes_ready=0 (core accepted) -> INIT_WAIT.
//  INIT_WAIT: wait aes_ready=1 -> NEXT if num_blocks!=0, else DONE.
//  NEXT: wait aes_ready=1; then aes_next=1 one cycle, trigger set same cycle -> NEXT_BUSY.
//  NEXT_BUSY: wait aes_ready=0 -> NEXT_WAIT (a stale result_valid is thereby ignored).
//  NEXT_WAIT: aes_ready=1 & aes_result_valid=1 -> trigger cleared, blocks_done+1;
//   blocks_done==num_blocks -> DONE, else -> GAP.
//  GAP: exactly GAP_CYC cycles, then NEXT. GAP_CYC=0 -> straight to NEXT.
//  DONE: done=1 one cycle -> IDLE. busy drops in the cycle after done.
//  aes_init and aes_next never both high; never high while aes_ready=0.
//  Latency (core ready): start edge -> aes_next high at 2nd following edge (rekey=0).
//  Watchdog: cycle counter clears on each state change; in INIT, INIT_BUSY, INIT_WAIT,
//   NEXT, NEXT_BUSY, NEXT_WAIT reaching TIMEOUT cycles -> error=1, trigger=0, go DONE.
//   blocks_done keeps the count reached.
//  blocks_done saturates at num_blocks; counter arithmetic is CNT_W wide, no wrap.
//  num_blocks=2**CNT_W-1 is legal and runs to completion.
// TESTING
//  rekey=1,num_blocks=1, core model ready-low 10 cyc -> 1 aes_init,1 aes_next, done, blocks_done=1.
//  rekey=0,num_blocks=3,GAP_CYC=4 -> 3 aes_next pulses, trigger lows >=4 cyc, blocks_done=3.
//  rekey=0,num_blocks=0 -> done pulse 2 cycles after start, no aes_init/aes_next, error=0.
//  core never raises result_valid, TIMEOUT=1024 -> error=1 and done after 1024 wait cycles.
//  reset_n low during NEXT_WAIT of block 2 -> all outputs 0 at once; new start runs cleanly.
//  start held high during a run, result_valid left high from prior block -> no extra run, no early count.

Source files
------------

// File: rtl/aes_sca_sequencer.sv
// Command-side sequencer for the AES core: expands one start request into init/next
// handshakes, counts results, frames each encryption with a scope trigger, and times out stalls.
module aes_sca_sequencer #(
    parameter int CNT_W   = 16,
    parameter int GAP_CYC = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             rekey,
    input  logic [CNT_W-1:0] num_blocks,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] blocks_done,
    output logic             trigger,
    output logic             aes_init,
    output logic             aes_next,
    input  logic             aes_ready,
    input  logic             aes_result_valid
);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_INIT_BUSY, S_INIT_WAIT,
        S_NEXT, S_NEXT_BUSY, S_NEXT_WAIT, S_GAP, S_DONE
    } state_t;

    // One counter serves as both the per-state watchdog and the gap timer.
    localparam int WD_W = $clog2(TIMEOUT + GAP_CYC + 2);
    localparam logic [WD_W-1:0] WD_LIM  = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] GAP_LIM = WD_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_t           state, state_d;
    logic [WD_W-1:0]  wd_cnt;
    logic [CNT_W-1:0] num_q, num_d, blk_inc, blocks_d;
    logic             accept, wd_fire, waiting, go;
    logic             busy_d, done_d, error_d, trigger_d, init_d, next_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            wd_cnt      <= '0;
            num_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            blocks_done <= '0;
            trigger     <= 1'b0;
            aes_init    <= 1'b0;
            aes_next    <= 1'b0;
        end else begin
            state       <= state_d;
            wd_cnt      <= (state_d != state) ? '0 :
                           (wd_cnt == '1) ? wd_cnt : wd_cnt + 1'b1;
            num_q       <= num_d;
            busy        <= busy_d;
            done        <= done_d;
            error       <= error_d;
            blocks_done <= blocks_d;
            trigger     <= trigger_d;
            aes_init    <= init_d;
            aes_next    <= next_d;
        end
    end

    always_comb begin
        state_d = state;
        num_d   = num_q;
        blk_inc = blocks_done + CNT_W'(1);
        go      = (state == S_IDLE) && start;
        accept  = (state == S_NEXT_WAIT) && aes_ready && aes_result_valid;
        waiting = state inside {S_INIT, S_INIT_BUSY, S_INIT_WAIT,
                                S_NEXT, S_NEXT_BUSY, S_NEXT_WAIT};
        unique case (state)
            S_IDLE: if (start) begin
                num_d = num_blocks;
                if (rekey)                state_d = S_INIT;
                else if (num_blocks != 0) state_d = S_NEXT;
                else                      state_d = S_DONE;
            end
            S_INIT:      if (aes_ready)  state_d = S_INIT_BUSY;
            S_INIT_BUSY: if (!aes_ready) state_d = S_INIT_WAIT;
            S_INIT_WAIT: if (aes_ready)  state_d = (num_q != 0) ? S_NEXT : S_DONE;
            S_NEXT:      if (aes_ready)  state_d = S_NEXT_BUSY;
            // Waiting for ready to drop first keeps a stale result_valid from counting.
            S_NEXT_BUSY: if (!aes_ready) state_d = S_NEXT_WAIT;
            S_NEXT_WAIT: if (accept)
                state_d = (blk_inc == num_q) ? S_DONE : ((GAP_CYC == 0) ? S_NEXT : S_GAP);
            S_GAP:       if (wd_cnt == GAP_LIM) state_d = S_NEXT;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
        wd_fire = waiting && (wd_cnt == WD_LIM) && (state_d == state);
        if (wd_fire) state_d = S_DONE;
    end

    always_comb begin
        busy_d    = (state_d != S_IDLE) || (state == S_DONE);
        done_d    = (state == S_DONE);
        init_d    = (state == S_INIT) && aes_ready;
        next_d    = (state == S_NEXT) && aes_ready;
        error_d   = go ? 1'b0 : (error | wd_fire);
        trigger_d = trigger;
        if (next_d)            trigger_d = 1'b1;
        if (accept || wd_fire) trigger_d = 1'b0;
        blocks_d  = blocks_done;
        if (go)                                  blocks_d = '0;
        else if (accept && blocks_done != num_q) blocks_d = blk_inc;
    end

endmodule
